// File: rtl/rf_scan_controller.sv
// Steps the receptive-field selector over every output row and column half,
// hands each bundle to the convolution engine and emits one buffer write per step.
module rf_scan_controller #(
    parameter int H      = 32,
    parameter int W      = 32,
    parameter int F      = 5,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [5:0]        rowNumber,
    output logic [5:0]        column,
    output logic              rf_valid,
    input  logic              rf_ready,
    input  logic              res_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int NUM_ROWS  = H - F + 1;
    localparam int NUM_STEPS = 2 * NUM_ROWS;

    generate
        if (((W - F + 1) % 2) != 0) begin : g_bad_width
            $error("rf_scan_controller: W-F+1 must be even");
        end
        if ((1 << ADDR_W) < NUM_STEPS) begin : g_bad_addr_w
            $error("rf_scan_controller: ADDR_W too small for NUM_STEPS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] row_q;
    logic       col_q;
    logic       step_done;
    logic       last_step;

    always_comb begin
        last_step = (row_q == 6'(NUM_ROWS - 1)) && col_q;
        step_done = (state_q == WAIT) && res_valid;
    end

    always_comb begin
        state_d   = state_q;
        rf_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        rowNumber = row_q;
        column    = 6'(col_q);
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                rf_valid = 1'b1;
                if (rf_ready) state_d = WAIT;
            end
            WAIT: begin
                if (res_valid) state_d = last_step ? DONE : ISSUE;
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Row/column only move on a completed step, so the selector input stays
    // stable across the whole ISSUE and WAIT of that step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= step_done;
            if ((state_q == IDLE) && start) begin
                row_q <= '0;
                col_q <= 1'b0;
            end
            if (step_done) begin
                wr_addr <= ADDR_W'({row_q, col_q});
                if (!last_step) begin
                    col_q <= ~col_q;
                    if (col_q) row_q <= row_q + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scan_controller.sv
// Scoreboard bench for rf_scan_controller: scans are queued as expected write
// addresses/cycles and a negedge monitor checks every wr_en and done pulse.
module tb_rf_scan_controller;

    localparam int ADDR_W = 6;
    localparam int NSTEP  = 56;
    localparam int NONE   = 999;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [5:0]        rowNumber;
    logic [5:0]        column;
    logic              rf_valid;
    logic              rf_ready;
    logic              res_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    typedef struct {
        int addr;
        int cyc;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    int      done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit eng_random = 1'b1;
    bit spurious   = 1'b0;
    int stall_step = NONE;
    int stall_left = 0;

    rf_scan_controller #(
        .H(32),
        .W(32),
        .F(5),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .rowNumber(rowNumber),
        .column(column),
        .rf_valid(rf_valid),
        .rf_ready(rf_ready),
        .res_valid(res_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int all_outs();
        return int'({busy, done, rf_valid, wr_en, rowNumber, column, wr_addr});
    endfunction

    // Engine model: accepts bundles (optionally stalling one step) and returns
    // the result in the first WAIT cycle.
    always @(negedge clk) begin
        if (eng_random) begin
            rf_ready  = 1'($urandom_range(0, 1));
            res_valid = 1'($urandom_range(0, 1));
        end else begin
            rf_ready  = 1'b0;
            res_valid = 1'b0;
            if (rf_valid) begin
                if ((int'(rowNumber) * 2 + int'(column)) == stall_step && stall_left > 0)
                    stall_left--;
                else
                    rf_ready = 1'b1;
                if (spurious) res_valid = 1'b1;
            end else if (busy && !done) begin
                res_valid = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or done.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_en_unexpected", int'(wr_en), 0);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", int'(done), 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    task automatic expect_scan(input int n0, input int s_step, input int s_n);
        for (int k = 0; k < NSTEP; k++) begin
            wr_exp_t e;
            e.addr = k;
            e.cyc  = n0 + 3 + 2 * k + ((k >= s_step) ? s_n : 0);
            wr_q.push_back(e);
        end
        done_q.push_back(n0 + 113 + s_n);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raises start for one cycle at the current negedge; returns that cycle.
    task automatic begin_scan(input int s_step, input int s_n, output int n0);
        n0    = cyc;
        start = 1'b1;
        expect_scan(n0, s_step, s_n);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int n1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        reset = 1'b1;

        // Idle with random engine inputs: nothing may move.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", all_outs(), 0);
        end
        eng_random = 1'b0;
        @(negedge clk);

        // Full scan, no stalls.
        begin_scan(NONE, 0, n0);
        wait_until(n0 + 41);
        check("step20_row", int'(rowNumber), 10);
        check("step20_col", int'(column), 0);
        check("step20_valid", int'(rf_valid), 1);
        wait_until(n0 + 113);
        check("busy_at_done", int'(busy), 1);
        wait_until(n0 + 114);
        check("busy_after", int'(busy), 0);
        check("pending_wr", wr_q.size(), 0);
        repeat (2) @(negedge clk);

        // Backpressure: 3 stall cycles on step 5 (row 2, column 1).
        stall_step = 5;
        stall_left = 3;
        begin_scan(5, 3, n0);
        for (int c = 11; c <= 13; c++) begin
            wait_until(n0 + c);
            check("stall_valid", int'(rf_valid), 1);
            check("stall_row", int'(rowNumber), 2);
            check("stall_col", int'(column), 1);
        end
        wait_until(n0 + 116);
        check("stall_busy_done", int'(busy), 1);
        wait_until(n0 + 117);
        check("stall_busy_after", int'(busy), 0);
        check("stall_pending", wr_q.size(), 0);
        stall_step = NONE;
        repeat (2) @(negedge clk);

        // Spurious res_valid in ISSUE and start pulses while busy / in DONE.
        spurious = 1'b1;
        begin_scan(NONE, 0, n0);
        wait_until(n0 + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(n0 + 51);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(n0 + 113);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("spur_busy_114", int'(busy), 0);
        @(negedge clk);
        check("spur_busy_115", int'(busy), 0);
        check("spur_pending", wr_q.size(), 0);
        spurious = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back: start held over DONE (ignored) and the following IDLE cycle.
        begin_scan(NONE, 0, n0);
        wait_until(n0 + 113);
        start = 1'b1;
        @(negedge clk);
        n1 = cyc;
        expect_scan(n1, NONE, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_row", int'(rowNumber), 0);
        check("b2b_restart_valid", int'(rf_valid), 1);
        wait_until(n1 + 113);
        check("b2b_busy_done", int'(busy), 1);
        wait_until(n1 + 114);
        check("b2b_busy_after", int'(busy), 0);
        check("b2b_pending", wr_q.size(), 0);
        repeat (2) @(negedge clk);

        // Mid-scan reset during WAIT of step 30 (row 15, column 0).
        begin_scan(NONE, 0, n0);
        wait_until(n0 + 62);
        check("pre_rst_valid", int'(rf_valid), 0);
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_row", int'(rowNumber), 15);
        check("pre_rst_col", int'(column), 0);
        check("pre_rst_written", wr_q.size(), NSTEP - 30);
        reset = 1'b0;
        #1;
        check("rst_outs", all_outs(), 0);
        wr_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        check("rst_hold_outs", all_outs(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        begin_scan(NONE, 0, n0);
        check("fresh_row", int'(rowNumber), 0);
        check("fresh_col", int'(column), 0);
        check("fresh_valid", int'(rf_valid), 1);
        wait_until(n0 + 114);
        check("fresh_busy_after", int'(busy), 0);
        check("fresh_pending", wr_q.size(), 0);
        check("fresh_done_pending", done_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
